// File: rtl/observer_scan_ctrl.sv
// Observer scan controller: walks observer mode/register selects and snapshots data_i once per entry.
// Optional macro OBS_SCAN_REG_SWEEP_EN: mode 0 sweeps reg 0..15 instead of a single reg_sel_i entry.
module observer_scan_ctrl #(
    parameter int unsigned DWELL     = 4,
    parameter logic [2:0]  LAST_MODE = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        step_i,
    input  logic [3:0]  reg_sel_i,
    input  logic [15:0] data_i,
    output logic [2:0]  mode_o,
    output logic [3:0]  reg_sel_o,
    output logic [15:0] snap_o,
    output logic        snap_valid_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t     state;
    logic [2:0] idx_mode;
    logic [7:0] cnt;
    logic       stop_flag;
    logic       step_mode;

    logic [2:0] nxt_mode;
    logic [3:0] nxt_sel;
    logic [3:0] cur_sel;
    logic       wrap;

`ifdef OBS_SCAN_REG_SWEEP_EN
    logic [3:0] idx_reg;
    logic [3:0] nxt_reg;

    always_comb begin
        nxt_mode = idx_mode;
        nxt_reg  = 4'd0;
        wrap     = 1'b0;
        if (idx_mode == 3'd0 && idx_reg != 4'hF) begin
            nxt_reg = idx_reg + 4'd1;
        end else if (idx_mode >= LAST_MODE) begin
            nxt_mode = 3'd0;
            wrap     = 1'b1;
        end else begin
            nxt_mode = idx_mode + 3'd1;
        end
        // Non-zero modes always carry reg 0, so the index register is the select.
        cur_sel = idx_reg;
        nxt_sel = nxt_reg;
    end
`else
    always_comb begin
        nxt_mode = idx_mode + 3'd1;
        wrap     = 1'b0;
        if (idx_mode >= LAST_MODE) begin
            nxt_mode = 3'd0;
            wrap     = 1'b1;
        end
        // Single mode-0 entry observes whichever register the host selects right now.
        cur_sel = (idx_mode == 3'd0) ? reg_sel_i : 4'd0;
        nxt_sel = (nxt_mode == 3'd0) ? reg_sel_i : 4'd0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx_mode     <= 3'd0;
`ifdef OBS_SCAN_REG_SWEEP_EN
            idx_reg      <= 4'd0;
`endif
            cnt          <= 8'd0;
            stop_flag    <= 1'b0;
            step_mode    <= 1'b0;
            mode_o       <= 3'd0;
            reg_sel_o    <= 4'd0;
            snap_o       <= 16'h0000;
            snap_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            snap_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    stop_flag <= 1'b0;
                    if (!stop_i && (start_i || step_i)) begin
                        step_mode <= !start_i;
                        state     <= SETTLE;
                        busy_o    <= 1'b1;
                        mode_o    <= idx_mode;
                        reg_sel_o <= cur_sel;
                    end
                end
                SETTLE: begin
                    if (stop_i) stop_flag <= 1'b1;
                    snap_o       <= data_i;
                    snap_valid_o <= 1'b1;
                    cnt          <= DWELL_M1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (stop_i) stop_flag <= 1'b1;
                    if (cnt == 8'd0) begin
                        idx_mode     <= nxt_mode;
`ifdef OBS_SCAN_REG_SWEEP_EN
                        idx_reg      <= nxt_reg;
`endif
                        frame_done_o <= wrap;
                        // Index is advanced even when stopping so the next start resumes after this entry.
                        if (stop_flag || stop_i || step_mode) begin
                            state     <= IDLE;
                            busy_o    <= 1'b0;
                            stop_flag <= 1'b0;
                        end else begin
                            state     <= SETTLE;
                            mode_o    <= nxt_mode;
                            reg_sel_o <= nxt_sel;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_observer_scan_ctrl.sv
// Directed bench for observer_scan_ctrl; expected snapshots come from a hand-written entry table.
module tb_observer_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, stop_i, step_i;
    logic [3:0]  reg_sel_i;
    logic [15:0] data_i;
    logic [2:0]  mode_o;
    logic [3:0]  reg_sel_o;
    logic [15:0] snap_o;
    logic        snap_valid_o, busy_o, frame_done_o;

    int n_cmp = 0;
    int n_err = 0;

`ifdef OBS_SCAN_REG_SWEEP_EN
    localparam int E = 21;
    logic [15:0] exp_snap [E] = '{
        16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
        16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h000B, 16'h000C, 16'h000D,
        16'h000E, 16'h000F, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
`else
    localparam int E = 6;
    logic [15:0] exp_snap [E] = '{
        16'h0007, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
`endif

    // Observer stand-in: mode in the upper byte, register in the low nibble.
    assign data_i = {5'h00, mode_o, 4'h0, reg_sel_o};

    observer_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .step_i       (step_i),
        .reg_sel_i    (reg_sel_i),
        .data_i       (data_i),
        .mode_o       (mode_o),
        .reg_sel_o    (reg_sel_o),
        .snap_o       (snap_o),
        .snap_valid_o (snap_valid_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        step_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Hold the given requests across one rising edge; returns at the negedge after it.
    task automatic kick(input logic s, input logic p, input logic t);
        start_i = s;
        stop_i  = p;
        step_i  = t;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        step_i  = 1'b0;
    endtask

    task automatic stop_and_wait(input int budget);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) break;
            @(negedge clk);
        end
        check("idle_after_stop", busy_o, 0);
    endtask

    initial begin
        int busy_cnt, vld_cnt, k2;
        reg_sel_i = 4'h7;

        // Reset state
        do_reset();
        check("rst_mode", mode_o, 0);
        check("rst_reg", reg_sel_o, 0);
        check("rst_snap", snap_o, 0);
        check("rst_valid", snap_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_frame", frame_done_o, 0);

        // Full frame in run mode, c counts negedges after the start edge
        kick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c <= 5 * E; c++) begin
            check("run_busy", busy_o, 1);
            check("run_valid", snap_valid_o, (c % 5) == 1);
            check("run_frame", frame_done_o, c == 5 * E);
            if ((c % 5) == 1) begin
                check("run_snap", snap_o, exp_snap[(c - 1) / 5]);
                check("run_mode", mode_o, exp_snap[(c - 1) / 5][10:8]);
            end
            if (c == 5 * E) begin
                check("wrap_mode", mode_o, exp_snap[0][10:8]);
                check("wrap_reg", reg_sel_o, exp_snap[0][3:0]);
            end
            if (c != 5 * E) @(negedge clk);
        end
        stop_and_wait(20);

        // Single step, then resume from the following entry
        do_reset();
        kick(1'b0, 1'b0, 1'b1);
        busy_cnt = 0;
        vld_cnt  = 0;
        for (int c = 0; c < 10; c++) begin
            busy_cnt += int'(busy_o);
            vld_cnt  += int'(snap_valid_o);
            @(negedge clk);
        end
        check("step_busy_cycles", busy_cnt, 5);
        check("step_valid_count", vld_cnt, 1);
        check("step_snap", snap_o, exp_snap[0]);
        kick(1'b1, 1'b0, 1'b0);
        check("step_resume_mode", mode_o, exp_snap[1][10:8]);
        check("step_resume_reg", reg_sel_o, exp_snap[1][3:0]);
        @(negedge clk);
        check("step_resume_snap", snap_o, exp_snap[1]);
        stop_and_wait(20);

        // Stop during HOLD of entry 3
        do_reset();
        kick(1'b1, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        @(negedge clk);
        check("stop_busy_last_hold", busy_o, 1);
        @(negedge clk);
        check("stop_idle", busy_o, 0);
        check("stop_snap", snap_o, exp_snap[3]);
        kick(1'b1, 1'b0, 1'b0);
        check("stop_resume_mode", mode_o, exp_snap[4][10:8]);
        check("stop_resume_reg", reg_sel_o, exp_snap[4][3:0]);
        @(negedge clk);
        check("stop_resume_snap", snap_o, exp_snap[4]);
        stop_and_wait(20);

        // Start and stop together in IDLE do nothing
        do_reset();
        kick(1'b1, 1'b1, 1'b0);
        busy_cnt = 0;
        vld_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            busy_cnt += int'(busy_o);
            vld_cnt  += int'(snap_valid_o);
            @(negedge clk);
        end
        check("startstop_busy", busy_cnt, 0);
        check("startstop_valid", vld_cnt, 0);

        // Start and step together select run mode: second entry follows
        kick(1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("startstep_busy", busy_o, 1);
        check("startstep_mode", mode_o, exp_snap[1][10:8]);
        check("startstep_reg", reg_sel_o, exp_snap[1][3:0]);
        stop_and_wait(20);

        // Reset during HOLD of the mode-2 entry
        do_reset();
        k2 = E - 4;
        kick(1'b1, 1'b0, 1'b0);
        repeat (5 * k2 + 2) @(negedge clk);
        check("pre_rst_mode", mode_o, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_mode", mode_o, 0);
        check("mid_rst_reg", reg_sel_o, 0);
        check("mid_rst_snap", snap_o, 0);
        check("mid_rst_valid", snap_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_frame", frame_done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", snap_valid_o, 0);
        kick(1'b1, 1'b0, 1'b0);
        check("restart_mode", mode_o, exp_snap[0][10:8]);
        check("restart_reg", reg_sel_o, exp_snap[0][3:0]);
        @(negedge clk);
        check("restart_valid", snap_valid_o, 1);
        check("restart_snap", snap_o, exp_snap[0]);
        stop_and_wait(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
